// File: rtl/sump_cmd_pkg.sv
// sump_cmd_pkg: shared types and constants for the SUMP command receiver.
// Holds the FSM state enum, long-command framing and opcode constants.
package sump_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    EXEC
  } state_e;

  localparam int LONG_CMD_BIT    = 7;
  localparam int LONG_DATA_BYTES = 4;

  localparam logic [7:0] CMD_RESET = 8'h00;
  localparam logic [7:0] CMD_RUN   = 8'h01;
  localparam logic [7:0] CMD_ID    = 8'h02;

endpackage

// File: rtl/sump_cmd_rx_if.sv
// sump_cmd_rx_if: byte-stream input and command output bundle.
// master drives bytes and consumes commands; slave is the receiver.
interface sump_cmd_rx_if;

  logic [7:0]  rxd_data;
  logic        rxd_valid;
  logic        rxd_ready;
  logic [7:0]  cmd_code;
  logic [31:0] cmd_data;
  logic        cmd_exe;
  logic        cmd_abort;

  modport master (
    output rxd_data,
    output rxd_valid,
    input  rxd_ready,
    input  cmd_code,
    input  cmd_data,
    input  cmd_exe,
    input  cmd_abort
  );

  modport slave (
    input  rxd_data,
    input  rxd_valid,
    output rxd_ready,
    output cmd_code,
    output cmd_data,
    output cmd_exe,
    output cmd_abort
  );

endinterface

// File: rtl/sump_cmd_rx_timer.sv
// sump_cmd_rx_timer: inter-byte timeout counter.
// tc_o pulses when enabled at TIMEOUT_CLKS-1; the count then restarts.
module sump_cmd_rx_timer #(
  parameter int TIMEOUT_CLKS = 100000,
  parameter int TW           = $clog2(TIMEOUT_CLKS)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CLKS - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  assign tc_o = en_i && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tc_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sump_cmd_rx.sv
// sump_cmd_rx: assembles SUMP host bytes into cmd_code/cmd_data/cmd_exe.
// Define SUMP_CMD_RX_ERRCNT_EN to add the saturating err_count port.
module sump_cmd_rx
  import sump_cmd_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
`ifdef SUMP_CMD_RX_ERRCNT_EN
  output logic [15:0] err_count,
`endif
  sump_cmd_rx_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam int IW = $clog2(LONG_DATA_BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(LONG_DATA_BYTES - 1);

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [7:0]    code_sh_q;
  logic [31:0]   data_sh_q;
  logic [31:0]   data_sh_d;
  logic [7:0]    code_q;
  logic [31:0]   data_q;
  logic          exe_q;
  logic          abort_q;
  logic          acc;
  logic          tmr_clr;
  logic          tmr_en;
  logic          tmr_tc;

  assign bus.rxd_ready = (state_q != EXEC);
  assign acc           = bus.rxd_valid && bus.rxd_ready;
  assign tmr_en        = (state_q == DATA) && !acc;
  assign tmr_clr       = (state_q != DATA) || acc;

  assign bus.cmd_code  = code_q;
  assign bus.cmd_data  = data_q;
  assign bus.cmd_exe   = exe_q;
  assign bus.cmd_abort = abort_q;

  always_comb begin
    data_sh_d = data_sh_q;
    data_sh_d[{idx_q, 3'b000} +: 8] = bus.rxd_data;
  end

  sump_cmd_rx_timer #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS),
    .TW           (TW)
  ) u_timer (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .tc_o  (tmr_tc)
  );

  // Outputs load on entry to EXEC so cmd_exe and the data share a cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      code_sh_q <= '0;
      data_sh_q <= '0;
      code_q    <= '0;
      data_q    <= '0;
      exe_q     <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      exe_q   <= 1'b0;
      abort_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            code_sh_q <= bus.rxd_data;
            if (bus.rxd_data[LONG_CMD_BIT]) begin
              idx_q   <= '0;
              state_q <= DATA;
            end else begin
              data_sh_q <= '0;
              code_q    <= bus.rxd_data;
              data_q    <= '0;
              exe_q     <= 1'b1;
              state_q   <= EXEC;
            end
          end
        end
        DATA: begin
          if (acc) begin
            data_sh_q <= data_sh_d;
            idx_q     <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              code_q  <= code_sh_q;
              data_q  <= data_sh_d;
              exe_q   <= 1'b1;
              state_q <= EXEC;
            end
          end else if (tmr_tc) begin
            idx_q     <= '0;
            code_sh_q <= '0;
            data_sh_q <= '0;
            abort_q   <= 1'b1;
            state_q   <= IDLE;
          end
        end
        EXEC: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef SUMP_CMD_RX_ERRCNT_EN
  logic [15:0] err_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      err_q <= '0;
    end else if (exe_q && (code_q == CMD_RESET)) begin
      err_q <= '0;
    end else if (abort_q && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_sump_cmd_rx.sv
// tb_sump_cmd_rx: directed byte streams with a queued scoreboard.
// A negedge monitor pops expected exe/abort events and checks them.
module tb_sump_cmd_rx;
  import sump_cmd_pkg::*;

  localparam int TO = 16;

  typedef struct {
    bit          abort;
    logic [7:0]  code;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   miscompares;
  exp_t sb[$];
  exp_t mon_e;
  logic [7:0]  last_code;
  logic [31:0] last_data;
  int   acc;
  int   first_acc;

`ifdef SUMP_CMD_RX_ERRCNT_EN
  logic [15:0] err_count;
`endif

  sump_cmd_rx_if bus ();

  sump_cmd_rx #(
    .TIMEOUT_CLKS (TO)
  ) dut (
    .sys_clk   (clk),
    .sys_rst   (rst),
`ifdef SUMP_CMD_RX_ERRCNT_EN
    .err_count (err_count),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && (bus.cmd_exe || bus.cmd_abort)) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {30'd0, bus.cmd_exe, bus.cmd_abort}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("event_is_abort", {31'd0, bus.cmd_abort}, {31'd0, mon_e.abort});
        chk("event_is_exe", {31'd0, bus.cmd_exe}, {31'd0, !mon_e.abort});
        chk("event_cycle", cyc, mon_e.due);
        chk("cmd_code", {24'd0, bus.cmd_code}, {24'd0, mon_e.code});
        chk("cmd_data", bus.cmd_data, mon_e.data);
        if (!mon_e.abort) begin
          chk("ready_in_exec", {31'd0, bus.rxd_ready}, 32'd0);
        end
      end
    end
  end

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic push_byte(input logic [7:0] b, input bit last,
                           input logic [7:0] ec, input logic [31:0] ed,
                           output int acc_cyc);
    int n;
    exp_t e;
    n = 0;
    bus.rxd_data  = b;
    bus.rxd_valid = 1'b1;
    while (!bus.rxd_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, bus.rxd_ready}, 32'd1);
    if (last) begin
      e.abort = 1'b0;
      e.code  = ec;
      e.data  = ed;
      e.due   = cyc + 1;
      sb.push_back(e);
      last_code = ec;
      last_data = ed;
    end
    @(negedge clk);
    acc_cyc = cyc;
  endtask

  task automatic idle(input int n);
    bus.rxd_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_short(input logic [7:0] op);
    int a;
    push_byte(op, 1'b1, op, 32'd0, a);
  endtask

  task automatic send_long(input logic [7:0] op, input logic [31:0] d,
                           input int gap);
    int a;
    logic [31:0] dv;
    dv = d;
    push_byte(op, 1'b0, 8'h00, 32'd0, a);
    for (int i = 0; i < 4; i++) begin
      if (gap > 0) idle(gap);
      push_byte(dv[8*i +: 8], (i == 3), op, d, a);
    end
  endtask

  task automatic send_aborted(input logic [7:0] op, input logic [7:0] b1);
    int a;
    exp_t e;
    push_byte(op, 1'b0, 8'h00, 32'd0, a);
    push_byte(b1, 1'b0, 8'h00, 32'd0, a);
    e.abort = 1'b1;
    e.code  = last_code;
    e.data  = last_data;
    e.due   = a + TO;
    sb.push_back(e);
    idle(TO + 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors       = 0;
    miscompares   = 0;
    last_code     = 8'h00;
    last_data     = 32'd0;
    rst           = 1'b1;
    bus.rxd_data  = 8'h00;
    bus.rxd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.rxd_ready}, 32'd1);
    chk("rst_code", {24'd0, bus.cmd_code}, 32'd0);
    chk("rst_data", bus.cmd_data, 32'd0);
    chk("rst_exe", {31'd0, bus.cmd_exe}, 32'd0);
    chk("rst_abort", {31'd0, bus.cmd_abort}, 32'd0);

    send_short(CMD_RUN);
    idle(2);
    send_long(8'hC0, 32'h12345678, 0);
    idle(2);

    send_aborted(8'h80, 8'hAA);
    send_short(CMD_ID);
    idle(2);

    push_byte(CMD_RESET, 1'b1, CMD_RESET, 32'd0, first_acc);
    for (int i = 0; i < 4; i++) begin
      push_byte(CMD_RESET, 1'b1, CMD_RESET, 32'd0, acc);
    end
    chk("five_zero_span", acc - first_acc, 32'd8);
    idle(2);

    // Bytes land exactly on the timer limit and must still be taken.
    send_long(8'h83, 32'hDEADBEEF, TO - 1);
    idle(2);

    push_byte(8'h80, 1'b0, 8'h00, 32'd0, acc);
    push_byte(8'h11, 1'b0, 8'h00, 32'd0, acc);
    push_byte(8'h22, 1'b0, 8'h00, 32'd0, acc);
    bus.rxd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_code", {24'd0, bus.cmd_code}, 32'd0);
    chk("midrst_data", bus.cmd_data, 32'd0);
    chk("midrst_exe", {31'd0, bus.cmd_exe}, 32'd0);
    chk("midrst_abort", {31'd0, bus.cmd_abort}, 32'd0);
    last_code = 8'h00;
    last_data = 32'd0;
    @(negedge clk);
    chk("midrst_ready", {31'd0, bus.rxd_ready}, 32'd1);
    send_long(8'h81, 32'h11223344, 0);
    idle(2);

`ifdef SUMP_CMD_RX_ERRCNT_EN
    send_short(CMD_RESET);
    idle(3);
    chk("err_cleared", {16'd0, err_count}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      send_aborted(8'h80 | 8'(i), 8'h55);
    end
    idle(2);
    chk("err_three", {16'd0, err_count}, 32'd3);
    send_short(CMD_RESET);
    idle(3);
    chk("err_reset", {16'd0, err_count}, 32'd0);
`endif

    idle(TO + 4);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sump_cmd_rx.md
Name: sump_cmd_rx

Overview:
- Initiator side of the core command interface: assembles the host's SUMP byte stream (from the UART/SPI byte receiver) into cmd_code/cmd_data/cmd_exe transactions for the core.
- Short commands are 1 byte (opcode bit7=0). Long commands are 5 bytes (opcode bit7=1, then 4 data bytes, LSB first).
- An inter-byte timeout discards partial long commands so the host can always resynchronise.

Parameters:
- TIMEOUT_CLKS, 100000, sys_clk cycles allowed between bytes of a long command before abort (must be >=2).
- TW, $clog2(TIMEOUT_CLKS), derived (localparam) width of the timeout counter.

Ports:
- sys_clk    input   1   block clock; all logic on rising edge
- sys_rst    input   1   reset; synchronous, active-high
- rxd_data   input   8   received byte
- rxd_valid  input   1   rxd_data valid; byte transferred when rxd_valid && rxd_ready
- rxd_ready  output  1   block can accept a byte this cycle
- cmd_code   output  8   opcode of the last completed command
- cmd_data   output  32  data of the last completed command (0 for short commands)
- cmd_exe    output  1   one-cycle pulse: cmd_code/cmd_data valid
- cmd_abort  output  1   one-cycle pulse: partial long command discarded on timeout

Behaviour:
- Reset values (sys_rst synchronous, wins over all other inputs):
  - state=IDLE; cmd_code=0x00, cmd_data=0, cmd_exe=0, cmd_abort=0; byte index=0; timer=0.
  - rxd_ready=1 in the cycle after reset deasserts.
- States: IDLE, DATA, EXEC.
- IDLE, byte accepted:
  - Latch byte into code_shadow.
  - bit7=0 -> EXEC, with data_shadow cleared to 0.
  - bit7=1 -> DATA, with index=0 and timer=0.
- DATA, byte accepted:
  - Write byte to data_shadow[8*index +: 8]; index++; timer=0.
  - The 4th byte (index==3) -> EXEC.
- DATA, no byte: timer++.
  - Abort when timer==TIMEOUT_CLKS-1: -> IDLE, cmd_abort=1 for 1 cycle, shadows discarded, cmd_code/cmd_data unchanged.
- EXEC (exactly 1 cycle):
  - cmd_code<=code_shadow, cmd_data<=data_shadow, cmd_exe=1; -> IDLE.
  - rxd_ready=0 in EXEC only; rxd_ready=1 in IDLE and DATA.
- Latency: the final byte is accepted in cycle N; cmd_exe is high in cycle N+1 with cmd_code/cmd_data already updated.
- cmd_code/cmd_data are held stable from the cmd_exe cycle until the next cmd_exe. They are registered outputs.
- Throughput: back-to-back short commands give a cmd_exe every 2 cycles (EXEC stalls the input for one cycle).
- Boundary conditions:
  - A byte arriving in the same cycle the timer hits its limit is accepted. The byte has priority and the timer is cleared.
  - Five consecutive 0x00 bytes (SUMP reset) produce five independent short-command cmd_exe pulses. No special handling.
  - A byte with bit7=1 received while in DATA is data, not a new opcode.
  - sys_rst in DATA or EXEC: the partial command is dropped, and no cmd_exe or cmd_abort is issued that cycle.
  - rxd_valid held high with rxd_ready=0: the byte is not consumed and is accepted the next cycle.

Optional Feature:
- Macro: SUMP_CMD_RX_ERRCNT_EN.
- Defined:
  - Adds output port err_count (16 bits), reset to 0.
  - err_count increments on each cmd_abort and saturates at 0xFFFF.
  - err_count clears on a cmd_exe with cmd_code==0x00.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package sump_cmd_pkg:
  - state enum {IDLE, DATA, EXEC}
  - LONG_CMD_BIT=7
  - LONG_DATA_BYTES=4
  - opcode constants CMD_RESET=0x00, CMD_RUN=0x01, CMD_ID=0x02
- One sub-module: sump_cmd_rx_timer (TW-bit counter with clear, enable, and terminal-count pulse).

Test Plan:
- Single byte 0x01 -> cmd_exe high 1 cycle after acceptance, cmd_code=0x01, cmd_data=0x00000000.
- Bytes 0xC0,0x78,0x56,0x34,0x12 on consecutive cycles -> cmd_exe once, cmd_code=0xC0, cmd_data=0x12345678.
- With TIMEOUT_CLKS=16: send 0x80,0xAA, then idle 16 cycles -> cmd_abort pulse, no cmd_exe. A following 0x02 -> cmd_code=0x02, cmd_data=0.
- Five 0x00 bytes with rxd_valid held high -> five cmd_exe pulses spaced 2 cycles apart, rxd_ready low in each EXEC cycle, no byte lost.
- Assert sys_rst after the 3rd byte of a long command -> outputs return to reset values, no cmd_exe. The next full long command decodes correctly.
- With SUMP_CMD_RX_ERRCNT_EN defined: three timeouts -> err_count=3. A 0x00 command -> err_count=0.
